// File: rtl/branch_pc_unit.sv
// PC and flag stage: ALU flag latch, LUT-steered branches, run/halt control.
// Optional FLAG_BYPASS_EN forwards ZeroIn/SignIn into same-cycle conditions.
module branch_pc_unit #(
  parameter int PCW  = 10,
  parameter int NTGT = 4
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Start,
  input  logic           Stall,
  input  logic           Halt,
  input  logic           FlagWE,
  input  logic           ZeroIn,
  input  logic           SignIn,
  input  logic [1:0]     BrOp,
  input  logic [1:0]     TgtIdx,
  input  logic           LutWE,
  input  logic [1:0]     LutAddr,
  input  logic [PCW-1:0] LutData,
  output logic [PCW-1:0] PC,
  output logic           FlagZ,
  output logic           FlagS,
  output logic           Taken,
  output logic           Done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t         state;
  logic [PCW-1:0] lut [NTGT];
  logic           cz;
  logic           cs;
  logic           take;

  // Condition flags seen by the branch decode.
`ifdef FLAG_BYPASS_EN
  assign cz = FlagWE ? ZeroIn : FlagZ;
  assign cs = FlagWE ? SignIn : FlagS;
`else
  assign cz = FlagZ;
  assign cs = FlagS;
`endif

  // Branch-taken decode.
  always_comb begin
    take = 1'b0;
    unique case (1'b1)
      (BrOp == 2'b11): take = 1'b1;
      (BrOp == 2'b01): take = cz;
      (BrOp == 2'b10): take = cs;
      default:         take = 1'b0;
    endcase
  end

  // Target table; writable in any state, branch reads the old value.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NTGT; i++) lut[i] <= '0;
    end else if (LutWE) begin
      lut[LutAddr] <= LutData;
    end
  end

  // Run/halt state machine, PC, flags and registered status.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      PC    <= '0;
      FlagZ <= 1'b0;
      FlagS <= 1'b0;
      Taken <= 1'b0;
      Done  <= 1'b0;
    end else begin
      Taken <= 1'b0;
      unique case (state)
        IDLE: begin
          PC <= '0;
          if (Start) state <= RUN;
        end
        RUN: begin
          if (FlagWE) begin
            FlagZ <= ZeroIn;
            FlagS <= SignIn;
          end
          if (Halt) begin
            state <= HALT;
            Done  <= 1'b1;
          end else if (Stall) begin
            PC <= PC;
          end else if (take) begin
            PC    <= lut[TgtIdx];
            Taken <= 1'b1;
          end else begin
            PC <= PC + PCW'(1);
          end
        end
        HALT: begin
          if (Start) begin
            state <= RUN;
            PC    <= '0;
            Done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          PC    <= '0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed self-checking bench for branch_pc_unit.
// Expected values are hand-computed per step.
module tb_branch_pc_unit;

  localparam int PCW = 10;

  logic           Clk = 1'b0;
  logic           Reset, Start, Stall, Halt, FlagWE;
  logic           ZeroIn, SignIn, LutWE;
  logic [1:0]     BrOp, TgtIdx, LutAddr;
  logic [PCW-1:0] LutData;
  logic [PCW-1:0] PC;
  logic           FlagZ, FlagS, Taken, Done;

  int n_cmp = 0;
  int n_err = 0;

  branch_pc_unit #(.PCW(PCW), .NTGT(4)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall),
    .Halt(Halt), .FlagWE(FlagWE), .ZeroIn(ZeroIn), .SignIn(SignIn),
    .BrOp(BrOp), .TgtIdx(TgtIdx), .LutWE(LutWE), .LutAddr(LutAddr),
    .LutData(LutData), .PC(PC), .FlagZ(FlagZ), .FlagS(FlagS),
    .Taken(Taken), .Done(Done)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [PCW-1:0] epc,
                        input logic et, input logic ed);
    chk({tag, ".pc"}, 32'(PC), 32'(epc));
    chk({tag, ".taken"}, 32'(Taken), 32'(et));
    chk({tag, ".done"}, 32'(Done), 32'(ed));
  endtask

  initial begin
    Reset = 1; Start = 0; Stall = 0; Halt = 0; FlagWE = 0;
    ZeroIn = 0; SignIn = 0; BrOp = 0; TgtIdx = 0;
    LutWE = 0; LutAddr = 0; LutData = 0;
    step();
    chk_st("reset", 10'h000, 0, 0);
    chk("reset.fz", 32'(FlagZ), 0);
    chk("reset.fs", 32'(FlagS), 0);

    Reset = 0;
    step();
    chk_st("idle_hold", 10'h000, 0, 0);
    Start = 1;
    step();
    chk_st("start", 10'h000, 0, 0);
    Start = 0;
    step(); chk_st("cnt1", 10'h001, 0, 0);
    step(); chk_st("cnt2", 10'h002, 0, 0);
    step(); chk_st("cnt3", 10'h003, 0, 0);
    Reset = 1;
    step(); chk_st("midreset", 10'h000, 0, 0);
    Reset = 0;
    step(); chk_st("idle_after_rst", 10'h000, 0, 0);

    LutWE = 1;
    LutAddr = 2; LutData = 10'h155; step();
    LutAddr = 1; LutData = 10'h020; step();
    LutAddr = 0; LutData = 10'h3FF; step();
    LutWE = 0;
    chk_st("preload_idle", 10'h000, 0, 0);

    Start = 1; step(); Start = 0;
    step(); step(); step(); step(); step();
    chk_st("pc5", 10'h005, 0, 0);
    BrOp = 2'b11; TgtIdx = 2;
    step(); chk_st("uncond", 10'h155, 1, 0);
    BrOp = 2'b00;
    step(); chk_st("taken_pulse", 10'h156, 0, 0);

    FlagWE = 1; ZeroIn = 1;
    step(); chk("fz_set", 32'(FlagZ), 1);
    chk_st("fz_set", 10'h157, 0, 0);
    FlagWE = 0; ZeroIn = 0; BrOp = 2'b01; TgtIdx = 1;
    step(); chk_st("beqz_taken", 10'h020, 1, 0);
    BrOp = 2'b00; FlagWE = 1; ZeroIn = 0;
    step(); chk("fz_clr", 32'(FlagZ), 0);
    chk_st("fz_clr", 10'h021, 0, 0);
    FlagWE = 0; BrOp = 2'b01;
    step(); chk_st("beqz_not", 10'h022, 0, 0);

    FlagWE = 1; SignIn = 1; BrOp = 2'b10; TgtIdx = 2;
    step();
`ifdef FLAG_BYPASS_EN
    chk_st("fuse_sign", 10'h155, 1, 0);
`else
    chk_st("fuse_sign", 10'h023, 0, 0);
`endif
    chk("fs_set", 32'(FlagS), 1);
    FlagWE = 0; SignIn = 0; BrOp = 2'b10; TgtIdx = 1;
    step(); chk_st("bneg_taken", 10'h020, 1, 0);

    BrOp = 2'b11; TgtIdx = 0;
    step(); chk_st("to_max", 10'h3FF, 1, 0);
    BrOp = 2'b00;
    step(); chk_st("wrap", 10'h000, 0, 0);

    Stall = 1; BrOp = 2'b11; TgtIdx = 2;
    FlagWE = 1; ZeroIn = 1; SignIn = 0;
    step(); chk_st("stall_br", 10'h000, 0, 0);
    chk("stall_fz", 32'(FlagZ), 1);
    chk("stall_fs", 32'(FlagS), 0);
    Stall = 0; FlagWE = 0; ZeroIn = 0;

    LutWE = 1; LutAddr = 1; LutData = 10'h0AA; TgtIdx = 1;
    step(); chk_st("lut_rd_old", 10'h020, 1, 0);
    LutWE = 0;
    step(); chk_st("lut_rd_new", 10'h0AA, 1, 0);
    BrOp = 2'b00;
    step(); chk_st("inc_ab", 10'h0AB, 0, 0);

    Halt = 1; BrOp = 2'b11;
    step(); chk_st("halt", 10'h0AB, 0, 1);
    Halt = 0; BrOp = 2'b00;
    step(); chk_st("halt_hold", 10'h0AB, 0, 1);
    FlagWE = 1; ZeroIn = 0; SignIn = 1;
    step(); chk("halt_fz", 32'(FlagZ), 1);
    chk("halt_fs", 32'(FlagS), 0);
    FlagWE = 0; SignIn = 0;
    Start = 1;
    step(); chk_st("restart", 10'h000, 0, 0);
    step(); chk_st("run_ign_start", 10'h001, 0, 0);
    Start = 0;
    step(); chk_st("resume", 10'h002, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
